// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell with a registered carry, LSB first
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic c_q, c_d, cout_q, cout_d, ovf_q, ovf_d, busy_q, done_q;
  logic s_bit, c_out, last;
  assign s_bit = a_q[0] ^ b_q[0] ^ c_q;
  assign c_out = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  assign last  = cnt_q == CNT_W'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = a_in;
        b_d     = b_in;
        c_d     = cin;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        p_d   = {s_bit, p_q[WIDTH-1:1]};
        c_d   = c_out;
        cnt_d = last ? cnt_q : cnt_q + 1'b1;
        if (last) begin
          sum_d   = p_d;
          cout_d  = c_out;
          ovf_d   = c_q ^ c_out;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= state_d == SHIFT;
      done_q  <= state_d == DONE;
    end
  end
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8 and an exhaustive WIDTH=3 sweep
module tb_serial_adder;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, cin = 1'b0;
  logic [7:0] a_in = '0, b_in = '0, sum;
  logic cout, overflow, busy, done;
  logic start3 = 1'b0, cin3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0, sum3;
  logic cout3, ovf3, busy3, done3;
  int checks = 0, errors = 0;
  typedef struct {logic [7:0] s; logic c; logic o;} exp_t;
  exp_t q8[$], q3[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .CNT_W(3)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .sum(sum), .cout(cout), .overflow(overflow), .busy(busy), .done(done));

  serial_adder #(.WIDTH(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a_in(a3), .b_in(b3), .cin(cin3),
    .sum(sum3), .cout(cout3), .overflow(ovf3), .busy(busy3), .done(done3));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q8.size() == 0) chk("unexpected_done8", 1, 0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("sum8", sum, e.s);
        chk("cout8", cout, e.c);
        chk("ovf8", overflow, e.o);
      end
    end
    if (done3) begin
      if (q3.size() == 0) chk("unexpected_done3", 1, 0);
      else begin
        exp_t e;
        e = q3.pop_front();
        chk("sum3", sum3, e.s);
        chk("cout3", cout3, e.c);
        chk("ovf3", ovf3, e.o);
      end
    end
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec, input logic eo, input bit disturb);
    exp_t e;
    int n, nb;
    bit got;
    @(posedge clk); #1;
    start = 1'b1; a_in = a; b_in = b; cin = c;
    e.s = es; e.c = ec; e.o = eo;
    q8.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom); cin = 1'($urandom);
    n = 0; nb = 0; got = 0;
    while (n < 30 && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1;
      else if (busy) nb++;
      if (disturb && n == 3) begin start = 1'b1; a_in = 8'hFF; b_in = 8'h77; end
      else if (disturb && n == 4) start = 1'b0;
    end
    if (!got) chk("done_timeout8", 0, 1);
    else begin
      chk("latency8", n, 9);
      chk("busy_cycles8", nb, 8);
      @(negedge clk);
      chk("done_pulse8", done, 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_busy3", busy3, 0);
    @(posedge clk); #1 rst = 1'b0;
    run8(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 0);
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    run8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 0);
    run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1);
    repeat (12) @(negedge clk);
    @(posedge clk); #1;
    start = 1'b1; a_in = 8'h11; b_in = 8'h22; cin = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    run8(8'h05, 8'h06, 1'b1, 8'h0C, 1'b0, 1'b0, 0);
    run8(8'hC0, 8'h90, 1'b0, 8'h50, 1'b1, 1'b1, 0);
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 2; c++) begin
          exp_t e;
          logic [3:0] r;
          logic [2:0] av, bv;
          int n;
          av = 3'(a); bv = 3'(b);
          r = 4'(a) + 4'(b) + 4'(c);
          e.s = {5'd0, r[2:0]};
          e.c = r[3];
          e.o = (av[2] == bv[2]) && (r[2] != av[2]);
          @(posedge clk); #1;
          start3 = 1'b1; a3 = av; b3 = bv; cin3 = 1'(c);
          q3.push_back(e);
          @(posedge clk); #1 start3 = 1'b0;
          n = 0;
          do begin
            @(negedge clk);
            n++;
          end while (!done3 && n < 20);
          if (!done3) chk("done_timeout3", 0, 1);
        end
    repeat (4) @(negedge clk);
    chk("pending8", q8.size(), 0);
    chk("pending3", q3.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
